mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl_pkg.sv | 19 +
 rtl/mem_wb_reg.sv | 41 ++++
 rtl/mem_stage_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller.
// Holds the datapath widths used by the rest of the pipeline, the FSM state
// encoding and a small address-alignment helper.
package mem_stage_ctrl_pkg;

  localparam int DSIZE = 32;  // datapath width, same as the pipeline
  localparam int ASIZE = 5;   // register-file address width

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // A word access is misaligned when either of the two byte-offset bits is set.
  function automatic logic misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                capture wen_d/waddr_d/wdata_d at the next edge
//   bubble              insert an empty slot (everything zero); wins over load
//   wen_d/waddr_d/wdata_d  next-stage write enable, destination, data
//   wen/waddr/wdata     registered MEM/WB contents
module mem_wb_reg #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic             wen_d,
  input  logic [ASIZE-1:0] waddr_d,
  input  logic [DSIZE-1:0] wdata_d,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata
);

  // MEM/WB register: bubble clears the slot so a stalled op is never written twice.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (load) begin
      wen   <= wen_d;
      waddr <= waddr_d;
      wdata <= wdata_d;
    end else begin
      wen   <= wen;
      waddr <= waddr;
      wdata <= wdata;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller.
// Takes the EXE/MEM register outputs, issues loads/stores to a variable-latency
// data memory over dmem_req/dmem_ack, stalls upstream while an access is
// outstanding and writes the selected result into the MEM/WB register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wen_in, alu_in, waddr_in,
//   rdata2_in, memRead_in,
//   memWrite_in, memtoReg_in       EXE/MEM register contents
//   stall                          combinational freeze of the upstream stages
//   dmem_req/we/addr/wdata         registered memory request
//   dmem_ack, dmem_rdata           memory completion and load data
//   wen_out, waddr_out, wdata_out  MEM/WB register
//   err                            sticky error (misaligned, read+write, timeout)
module mem_stage_ctrl #(
  parameter int DSIZE   = mem_stage_ctrl_pkg::DSIZE,
  parameter int ASIZE   = mem_stage_ctrl_pkg::ASIZE,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_in,
  input  logic [DSIZE-1:0] alu_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  logic             memtoReg_in,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [AW-1:0]    dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             wen_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic [DSIZE-1:0] wdata_out,
  output logic             err
);

  import mem_stage_ctrl_pkg::*;

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t state_r, state_next_s;

  logic [CW-1:0]    wait_cnt_r;
  logic             req_r;
  logic             we_r;
  logic [AW-1:0]    addr_r;
  logic [DSIZE-1:0] wdata_r;
  logic             wen_r;
  logic [ASIZE-1:0] waddr_r;
  logic             mtr_r;
  logic [DSIZE-1:0] alu_r;
  logic             err_r;

  logic             memop_s;
  logic             timeout_hit_s;
  logic             complete_s;
  logic             start_s;
  logic             err_set_s;
  logic             wb_wen_s;
  logic [ASIZE-1:0] wb_waddr_s;
  logic [DSIZE-1:0] wb_wdata_s;

  // FSM next state, stall, MEM/WB selection and error detection.
  always_comb begin
    memop_s       = memRead_in | memWrite_in;
    timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT - 1));
    complete_s    = dmem_ack | timeout_hit_s;
    state_next_s  = state_r;
    stall         = 1'b0;
    start_s       = 1'b0;
    err_set_s     = 1'b0;
    wb_wen_s      = wen_in;
    wb_waddr_s    = waddr_in;
    wb_wdata_s    = alu_in;
    case (state_r)
      ST_IDLE: begin
        if (memop_s) begin
          stall        = 1'b1;
          start_s      = 1'b1;
          state_next_s = ST_WAIT;
          // Read+write together is serviced as a read but still flagged.
          err_set_s    = (memRead_in & memWrite_in) | misaligned(alu_in[1:0]);
        end else begin
          stall        = 1'b0;
        end
      end
      ST_WAIT: begin
        wb_wen_s   = wen_r;
        wb_waddr_s = waddr_r;
        if (mtr_r && !we_r) begin
          // A timed-out load writes back zero rather than stale bus data.
          wb_wdata_s = dmem_ack ? dmem_rdata : {DSIZE{1'b0}};
        end else begin
          wb_wdata_s = alu_r;
        end
        if (complete_s) begin
          state_next_s = ST_IDLE;
          // Ack wins over a coincident timeout.
          err_set_s    = ~dmem_ack;
        end else begin
          stall        = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, request, latched access fields, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      wen_r      <= 1'b0;
      waddr_r    <= '0;
      mtr_r      <= 1'b0;
      alu_r      <= '0;
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_r   <= (state_next_s == ST_WAIT);
      err_r   <= err_r | err_set_s;
      if (start_s) begin
        we_r       <= memWrite_in & ~memRead_in;
        addr_r     <= alu_in[AW+1:2];
        wdata_r    <= rdata2_in;
        wen_r      <= wen_in;
        waddr_r    <= waddr_in;
        mtr_r      <= memtoReg_in;
        alu_r      <= alu_in;
        wait_cnt_r <= '0;
      end else if (state_r == ST_WAIT && !complete_s) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign dmem_req   = req_r;
  assign dmem_we    = we_r;
  assign dmem_addr  = addr_r;
  assign dmem_wdata = wdata_r;
  assign err        = err_r;

  mem_wb_reg #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (~stall),
    .bubble (stall),
    .wen_d  (wb_wen_s),
    .waddr_d(wb_waddr_s),
    .wdata_d(wb_wdata_s),
    .wen    (wen_out),
    .waddr  (waddr_out),
    .wdata  (wdata_out)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen_in;
  logic [31:0] alu_in;
  logic [4:0]  waddr_in;
  logic [31:0] rdata2_in;
  logic        memRead_in, memWrite_in, memtoReg_in;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wen_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_ctrl #(.DSIZE(32), .ASIZE(5), .AW(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .wen_in(wen_in), .alu_in(alu_in), .waddr_in(waddr_in),
    .rdata2_in(rdata2_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memtoReg_in(memtoReg_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wen_out(wen_out), .waddr_out(waddr_out),
    .wdata_out(wdata_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic        mtr;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } alu_vec_t;

  alu_vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic wen, input logic [31:0] alu, input logic [4:0] wa,
                        input logic [31:0] rd2, input logic mr, input logic mw, input logic mtr);
    wen_in = wen; alu_in = alu; waddr_in = wa; rdata2_in = rd2;
    memRead_in = mr; memWrite_in = mw; memtoReg_in = mtr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one memory access whose request is already on the inputs; acks on
  // WAIT cycle ack_at (0 = never). Returns stall/WAIT cycle counts and the
  // request fields seen in the first WAIT cycle. Leaves a nop on the inputs.
  task automatic run_access(input int ack_at, input logic [31:0] rd,
                            output int stalls, output int waits,
                            output logic c_we, output logic [7:0] c_addr,
                            output logic [31:0] c_wdata);
    logic done;
    stalls = 0; waits = 0; c_we = 1'b0; c_addr = 8'h0; c_wdata = 32'h0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req) begin
        waits++;
        dmem_ack = (waits == ack_at);
        dmem_rdata = rd;
        if (waits == 1) begin
          c_we = dmem_we; c_addr = dmem_addr; c_wdata = dmem_wdata;
        end
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      done = dmem_req && !stall;
      if (stall) stalls++;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (done) begin
        set_in(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL access_bound: got no completion within 40 cycles, expected completion");
    set_in(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int st, wt;
    logic cwe;
    logic [7:0] cad;
    logic [31:0] cwd;

    vecs[0] = '{1'b1, 32'h0000_1234, 5'd3,  1'b0, 1'b1, 5'd3,  32'h0000_1234};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'hA5A5_0003, 5'd0,  1'b0, 1'b1, 5'd0,  32'hA5A5_0003};
    vecs[3] = '{1'b1, 32'h8000_0000, 5'd16, 1'b1, 1'b1, 5'd16, 32'h8000_0000};

    // Reset state
    do_reset();
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_we", {31'h0, dmem_we}, 32'h0);
    chk("rst_addr", {24'h0, dmem_addr}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wen", {31'h0, wen_out}, 32'h0);
    chk("rst_waddr", {27'h0, waddr_out}, 32'h0);
    chk("rst_wdata_out", wdata_out, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Non-memory ops: one cycle into MEM/WB, never stall
    for (int i = 0; i < 4; i++) begin
      set_in(vecs[i].wen, vecs[i].alu, vecs[i].waddr, 32'h5555_5555, 1'b0, 1'b0, vecs[i].mtr);
      #1;
      chk("alu_stall", {31'h0, stall}, 32'h0);
      tick();
      chk("alu_wen", {31'h0, wen_out}, {31'h0, vecs[i].exp_wen});
      chk("alu_waddr", {27'h0, waddr_out}, {27'h0, vecs[i].exp_waddr});
      chk("alu_wdata", wdata_out, vecs[i].exp_wdata);
      chk("alu_req", {31'h0, dmem_req}, 32'h0);
    end
    chk("alu_err", {31'h0, err}, 32'h0);

    // Load, ack on third WAIT cycle
    set_in(1'b1, 32'h0000_0040, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1);
    run_access(3, 32'hDEAD_BEEF, st, wt, cwe, cad, cwd);
    chk("ld_stalls", st, 32'd3);
    chk("ld_waits", wt, 32'd3);
    chk("ld_addr", {24'h0, cad}, 32'h10);
    chk("ld_we", {31'h0, cwe}, 32'h0);
    chk("ld_wdata_out", wdata_out, 32'hDEAD_BEEF);
    chk("ld_wen", {31'h0, wen_out}, 32'h1);
    chk("ld_waddr", {27'h0, waddr_out}, 32'd7);
    chk("ld_req_drop", {31'h0, dmem_req}, 32'h0);
    chk("ld_err", {31'h0, err}, 32'h0);

    // Store, ack on first WAIT cycle
    set_in(1'b0, 32'h0000_0008, 5'd9, 32'h0000_CAFE, 1'b0, 1'b1, 1'b0);
    run_access(1, 32'h1111_1111, st, wt, cwe, cad, cwd);
    chk("st_stalls", st, 32'd1);
    chk("st_we", {31'h0, cwe}, 32'h1);
    chk("st_addr", {24'h0, cad}, 32'h2);
    chk("st_wdata", cwd, 32'h0000_CAFE);
    chk("st_wen", {31'h0, wen_out}, 32'h0);
    chk("st_err", {31'h0, err}, 32'h0);

    // Ack coincident with timeout: data used, no error
    set_in(1'b1, 32'h0000_0044, 5'd4, 32'h0, 1'b1, 1'b0, 1'b1);
    run_access(15, 32'h1357_9BDF, st, wt, cwe, cad, cwd);
    chk("coin_waits", wt, 32'd15);
    chk("coin_wdata", wdata_out, 32'h1357_9BDF);
    chk("coin_err", {31'h0, err}, 32'h0);

    // Timeout without ack
    set_in(1'b1, 32'h0000_0040, 5'd5, 32'h0, 1'b1, 1'b0, 1'b1);
    run_access(0, 32'hFFFF_0000, st, wt, cwe, cad, cwd);
    chk("to_waits", wt, 32'd15);
    chk("to_stalls", st, 32'd15);
    chk("to_wdata", wdata_out, 32'h0);
    chk("to_wen", {31'h0, wen_out}, 32'h1);
    chk("to_err", {31'h0, err}, 32'h1);
    set_in(1'b1, 32'h0000_0077, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("to_err_sticky", {31'h0, err}, 32'h1);
    chk("to_alu_after", wdata_out, 32'h0000_0077);

    // Reset in the middle of WAIT
    set_in(1'b1, 32'h0000_0080, 5'd6, 32'h0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk("mid_req_hi", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1;
    set_in(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("mid_req", {31'h0, dmem_req}, 32'h0);
    chk("mid_addr", {24'h0, dmem_addr}, 32'h0);
    chk("mid_wen", {31'h0, wen_out}, 32'h0);
    chk("mid_wdata", wdata_out, 32'h0);
    chk("mid_err", {31'h0, err}, 32'h0);
    set_in(1'b1, 32'h0000_1234, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_alu_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("mid_alu_wen", {31'h0, wen_out}, 32'h1);
    chk("mid_alu_wdata", wdata_out, 32'h0000_1234);
    chk("mid_alu_waddr", {27'h0, waddr_out}, 32'd3);

    // Read and write together: serviced as a read, error flagged
    set_in(1'b1, 32'h0000_0004, 5'd8, 32'h0000_BEEF, 1'b1, 1'b1, 1'b1);
    run_access(1, 32'h2468_ACE0, st, wt, cwe, cad, cwd);
    chk("rw_we", {31'h0, cwe}, 32'h0);
    chk("rw_addr", {24'h0, cad}, 32'h1);
    chk("rw_wdata", wdata_out, 32'h2468_ACE0);
    chk("rw_err", {31'h0, err}, 32'h1);

    // Misaligned load
    do_reset();
    set_in(1'b1, 32'h0000_0041, 5'd1, 32'h0, 1'b1, 1'b0, 1'b1);
    run_access(1, 32'h0BAD_F00D, st, wt, cwe, cad, cwd);
    chk("mis_addr", {24'h0, cad}, 32'h10);
    chk("mis_wdata", wdata_out, 32'h0BAD_F00D);
    chk("mis_err", {31'h0, err}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
